// File: rtl/value_display_if.sv
// value_display_if: bundles the parameter-bank read side and the seven-segment
// display outputs of value_display.
//   master : drives sel, hold and the nine 16.8 parameters; receives the display.
//   slave  : value_display itself.
// Signals: sel[3:0], hold, offsetx..angle[23:0] (16.8 fixed point),
//          seg[6:0] {g,f,e,d,c,b,a} active-low, dp active-low,
//          an[3:0] active-low digit enables (an[0] rightmost), sel_valid.
interface value_display_if;
    logic [3:0]  sel;
    logic        hold;
    logic [23:0] offsetx;
    logic [23:0] offsety;
    logic [23:0] originx;
    logic [23:0] originy;
    logic [23:0] texturew;
    logic [23:0] textureh;
    logic [23:0] scalex;
    logic [23:0] scaley;
    logic [23:0] angle;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        sel_valid;

    modport master (
        output sel, hold, offsetx, offsety, originx, originy,
               texturew, textureh, scalex, scaley, angle,
        input  seg, dp, an, sel_valid
    );

    modport slave (
        input  sel, hold, offsetx, offsety, originx, originy,
               texturew, textureh, scalex, scaley, angle,
        output seg, dp, an, sel_valid
    );
endinterface

// File: rtl/value_display.sv
// value_display: shows the Mode7 parameter selected by sel as four hex digits
// on a multiplexed, active-low seven-segment display.
//   clk_slow  : clock shared with the parameter bank
//   reset     : synchronous, active-high; wins over everything
//   bus       : value_display_if.slave (sel, hold, parameters in; seg, dp,
//               an, sel_valid out)
// Pipeline: snapshot register -> scan/page state -> registered outputs, so an
// input change reaches the pins two edges later.
// Parameters: SCAN_DIV (cycles per digit, >= 1), PAGE_DIV (cycles per page,
// >= 2, only meaningful with paging).
// Build option: define VALUE_DISPLAY_FRAC_EN to alternate between the integer
// page and a fraction page; without it only the integer part is shown.
module value_display #(
    parameter int SCAN_DIV = 4,
    parameter int PAGE_DIV = 256
) (
    input  logic           clk_slow,
    input  logic           reset,
    value_display_if.slave bus
);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        PAGE_INT  = 1'b0,
        PAGE_FRAC = 1'b1
    } page_e;

    if (SCAN_DIV < 1) begin : g_bad_scan_div
        $error("value_display: SCAN_DIV must be 1 or more");
    end
    if (PAGE_DIV < 2) begin : g_bad_page_div
        $error("value_display: PAGE_DIV must be 2 or more");
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [23:0]       snap_q, snap_d;
    logic              snap_ok_q, snap_ok_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              sel_valid_q, sel_valid_d;
    logic [23:0]       sel_value;
    logic [3:0]        nib_int;
    logic [3:0]        nib_frac;
    logic              scan_wrap;
    page_e             page_q;

    // Parameter mux; indices above 8 read as zero.
    always_comb begin
        case (bus.sel)
            4'd0:    sel_value = bus.offsetx;
            4'd1:    sel_value = bus.offsety;
            4'd2:    sel_value = bus.originx;
            4'd3:    sel_value = bus.originy;
            4'd4:    sel_value = bus.texturew;
            4'd5:    sel_value = bus.textureh;
            4'd6:    sel_value = bus.scalex;
            4'd7:    sel_value = bus.scaley;
            4'd8:    sel_value = bus.angle;
            default: sel_value = '0;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned, which would infer a latch.
        snap_d    = snap_q;
        snap_ok_d = snap_ok_q;
        if (!bus.hold) begin
            snap_d    = sel_value;
            snap_ok_d = (bus.sel <= 4'd8);
        end
    end

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_d    = scan_wrap ? digit_q + 2'd1 : digit_q;
    end

`ifdef VALUE_DISPLAY_FRAC_EN
    localparam int PAGE_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;

    // Only paging needs the latched index: a new selection restarts on the
    // integer page so the operator first sees the integer part.
    logic [3:0]        snap_sel_q, snap_sel_d;
    logic [PAGE_W-1:0] page_cnt_q, page_cnt_d;
    page_e             page_d;

    always_comb begin
        snap_sel_d = bus.hold ? snap_sel_q : bus.sel;
        page_d     = page_q;
        page_cnt_d = page_cnt_q + PAGE_W'(1);
        if (snap_sel_d != snap_sel_q) begin
            page_d     = PAGE_INT;
            page_cnt_d = '0;
        end else if (page_cnt_q == PAGE_W'(PAGE_DIV - 1)) begin
            page_cnt_d = '0;
            page_d     = (page_q == PAGE_INT) ? PAGE_FRAC : PAGE_INT;
        end
    end

    always_ff @(posedge clk_slow) begin
        if (reset) begin
            snap_sel_q <= '0;
            page_cnt_q <= '0;
            page_q     <= PAGE_INT;
        end else begin
            snap_sel_q <= snap_sel_d;
            page_cnt_q <= page_cnt_d;
            page_q     <= page_d;
        end
    end
`else
    assign page_q = PAGE_INT;
`endif

    always_comb begin
        case (digit_q)
            2'd0:    nib_int = snap_q[11:8];
            2'd1:    nib_int = snap_q[15:12];
            2'd2:    nib_int = snap_q[19:16];
            default: nib_int = snap_q[23:20];
        endcase
        nib_frac = digit_q[0] ? snap_q[7:4] : snap_q[3:0];

        an_d        = ~(4'b0001 << digit_q);
        sel_valid_d = snap_ok_q;
        dp_d        = 1'b1;
        if (!snap_ok_q) begin
            seg_d = 7'h3F;                      // dash on both pages
        end else if (page_q == PAGE_INT) begin
            seg_d = hex7(nib_int);
        end else if (!digit_q[1]) begin
            seg_d = hex7(nib_frac);
        end else begin
            // Upper fraction digits are blank; the point on digit 2 marks
            // the "0.xx" reading.
            seg_d = 7'h7F;
            dp_d  = (digit_q != 2'd2);
        end
    end

    always_ff @(posedge clk_slow) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            snap_q      <= '0;
            snap_ok_q   <= 1'b0;
            scan_cnt_q  <= '0;
            digit_q     <= '0;
            an_q        <= 4'b1111;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            sel_valid_q <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            snap_ok_q   <= snap_ok_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.sel_valid = sel_valid_q;
endmodule
